// File: rtl/m10k_arbiter_ctrl.sv
// Round-robin shared single-port RAM controller: one access per cycle, per-byte writes, reads answered READ_LAT cycles after accept.
// Backpressure is by grant only: req_ready picks one valid port per cycle and unaccepted requests must be held by the requester.
module m10k_arbiter_ctrl #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int NUM_PORTS = 2,
    parameter int READ_LAT  = 2
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_PORTS-1:0]                 req_valid,
    output logic [NUM_PORTS-1:0]                 req_ready,
    input  logic [NUM_PORTS-1:0]                 req_write,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]     req_wdata,
    input  logic [NUM_PORTS-1:0][DATA_W/8-1:0]   req_be,
    output logic [NUM_PORTS-1:0]                 rsp_valid,
    output logic [DATA_W-1:0]                    rsp_data,
    output logic                                 busy
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W  = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;
    int                cand;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic              in_range;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] rd_word;

    logic [NUM_PORTS-1:0] pipe_port;
    logic                 pipe_vld;
    logic [DATA_W-1:0]    pipe_data;
    logic                 stage_busy;

    // Scan downwards so the last hit is the first valid port after ptr.
    always_comb begin
        gnt_idx   = ptr;
        gnt_any   = 1'b0;
        req_ready = '0;
        cand      = 0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            cand = (int'(ptr) + i) % NUM_PORTS;
            if (req_valid[cand]) begin
                gnt_idx = PTR_W'(cand);
                gnt_any = 1'b1;
            end
        end
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    assign sel_write = req_write[gnt_idx];
    assign sel_addr  = req_addr[gnt_idx];
    assign sel_wdata = req_wdata[gnt_idx];
    assign sel_be    = req_be[gnt_idx];
    assign in_range  = ({1'b0, sel_addr} < DEPTH_CMP);
    assign rd_acc    = gnt_any & ~sel_write;
    assign wr_acc    = gnt_any & sel_write & in_range & reset_n;
    assign rd_word   = in_range ? mem[sel_addr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= PTR_W'(NUM_PORTS - 1);
        end else if (gnt_any) begin
            ptr <= gnt_idx;
        end
    end

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic                 s1_vld;
            logic [NUM_PORTS-1:0] s1_port;
            logic [DATA_W-1:0]    s1_data;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    s1_vld  <= 1'b0;
                    s1_port <= '0;
                    s1_data <= '0;
                end else begin
                    s1_vld  <= rd_acc;
                    s1_port <= rd_acc ? req_ready : '0;
                    if (rd_acc) s1_data <= rd_word;
                end
            end

            assign pipe_vld   = s1_vld;
            assign pipe_port  = s1_port;
            assign pipe_data  = s1_data;
            assign stage_busy = s1_vld;
        end else begin : g_lat1
            assign pipe_vld   = rd_acc;
            assign pipe_port  = req_ready;
            assign pipe_data  = rd_word;
            assign stage_busy = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= pipe_vld ? pipe_port : '0;
            if (pipe_vld) rsp_data <= pipe_data;
        end
    end

    assign busy = stage_busy | (|rsp_valid);

endmodule

// File: tb/tb_m10k_arbiter_ctrl.sv
// Two builds (READ_LAT 2 and 1, DEPTH 200) share one request stream; each response stream is scored against a queue of expected reads.
module tb_m10k_arbiter_ctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 200;
    localparam int AW    = $clog2(DEPTH);
    localparam int NP    = 2;

    logic clock;
    logic reset_n;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [NP-1:0]         req_valid, req_write;
    logic [NP-1:0][AW-1:0] req_addr;
    logic [NP-1:0][DW-1:0] req_wdata;
    logic [NP-1:0][3:0]    req_be;
    logic [NP-1:0]         rdy_a, rdy_b, vld_a, vld_b;
    logic [DW-1:0]         dat_a, dat_b;
    logic                  busy_a, busy_b;

    m10k_arbiter_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_PORTS(NP), .READ_LAT(2)) u_lat2 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld_a), .rsp_data(dat_a), .busy(busy_a));

    m10k_arbiter_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_PORTS(NP), .READ_LAT(1)) u_lat1 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(vld_b), .rsp_data(dat_b), .busy(busy_b));

    typedef struct {
        int          port;
        logic [31:0] data;
        bit          known;
        int          acc;
    } rd_t;

    rd_t         rd_q[$];
    int          head[2];
    logic [31:0] last_d[2];
    bit          last_k[2];
    logic [31:0] mmem[DEPTH];
    bit          mknown[DEPTH];
    int          mptr;
    int          ec;
    int          checks;
    int          failures;

    bit          p_on[NP];
    bit          p_wr[NP];
    int          p_addr[NP];
    logic [31:0] p_dat[NP];
    logic [3:0]  p_be[NP];

    always @(posedge clock) ec <= ec + 1;

    task automatic chk(input string nm, input int w, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[dut%0d] edge %0d: got %h expected %h", nm, w, ec, act, exp);
        end
    endtask

    task automatic mon(input int w, input int lat, input logic [NP-1:0] v,
                       input logic [31:0] d, input logic b);
        logic [NP-1:0] ev;
        bit fut, inf;
        if (!reset_n) begin
            chk("rst_valid", w, 32'(v), 32'd0);
            chk("rst_data", w, d, 32'd0);
            chk("rst_busy", w, 32'(b), 32'd0);
            return;
        end
        ev  = '0;
        fut = 0;
        inf = 0;
        for (int i = head[w]; i < rd_q.size(); i++) begin
            if (rd_q[i].acc <= ec) begin
                inf = 1;
                if (rd_q[i].acc + lat - 1 > ec) fut = 1;
            end
        end
        if (head[w] < rd_q.size() && rd_q[head[w]].acc + lat - 1 <= ec) begin
            ev[rd_q[head[w]].port] = 1'b1;
            last_k[w] = rd_q[head[w]].known;
            last_d[w] = rd_q[head[w]].data;
            head[w]++;
        end
        chk("rsp_valid", w, 32'(v), 32'(ev));
        if (last_k[w]) chk("rsp_data", w, d, last_d[w]);
        if (fut) chk("busy_hi", w, 32'(b), 32'd1);
        else if (!inf) chk("busy_lo", w, 32'(b), 32'd0);
    endtask

    always @(negedge clock) begin
        mon(0, 2, vld_a, dat_a, busy_a);
        mon(1, 1, vld_b, dat_b, busy_b);
    end

    // Reference effect of an accepted request on the abstract memory and expected read stream.
    task automatic apply(input int g);
        int a;
        a = p_addr[g];
        mptr = g;
        p_on[g] = 0;
        if (p_wr[g]) begin
            if (a < DEPTH) begin
                for (int b = 0; b < 4; b++)
                    if (p_be[g][b]) mmem[a][b*8 +: 8] = p_dat[g][b*8 +: 8];
                if (p_be[g] == 4'hF) mknown[a] = 1;
            end
        end else begin
            rd_q.push_back('{g, (a < DEPTH) ? mmem[a] : 32'd0, (a >= DEPTH) || mknown[a], ec + 1});
        end
    endtask

    task automatic step();
        int g;
        logic [NP-1:0] eready;
        @(posedge clock);
        #1;
        for (int p = 0; p < NP; p++) begin
            req_valid[p] = p_on[p];
            req_write[p] = p_wr[p];
            req_addr[p]  = AW'(p_addr[p]);
            req_wdata[p] = p_dat[p];
            req_be[p]    = p_be[p];
        end
        #1;
        g = -1;
        for (int i = 1; i <= NP; i++) begin
            int c;
            c = (mptr + i) % NP;
            if (g < 0 && p_on[c]) g = c;
        end
        eready = '0;
        if (g >= 0) eready[g] = 1'b1;
        chk("req_ready", 0, 32'(rdy_a), 32'(eready));
        chk("req_ready", 1, 32'(rdy_b), 32'(eready));
        if (g >= 0) apply(g);
    endtask

    task automatic put(input int p, input bit wr, input int a, input logic [31:0] d, input logic [3:0] be);
        p_on[p]   = 1;
        p_wr[p]   = wr;
        p_addr[p] = a;
        p_dat[p]  = d;
        p_be[p]   = be;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((p_on[0] || p_on[1]) && n < 50) begin
            step();
            n++;
        end
        if (p_on[0] || p_on[1]) begin
            failures++;
            $display("FAIL drain: requests still pending after %0d cycles", n);
            p_on[0] = 0;
            p_on[1] = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        req_valid = '0;
        for (int p = 0; p < NP; p++) p_on[p] = 0;
        for (int w = 0; w < 2; w++) begin
            head[w]   = rd_q.size();
            last_d[w] = 32'd0;
            last_k[w] = 1;
        end
        mptr = NP - 1;
        repeat (n) @(posedge clock);
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        ec = 0; checks = 0; failures = 0; mptr = NP - 1;
        for (int w = 0; w < 2; w++) begin
            head[w] = 0; last_d[w] = 32'd0; last_k[w] = 1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            mmem[i] = 32'd0; mknown[i] = 0;
        end
        for (int p = 0; p < NP; p++) begin
            p_on[p] = 0; p_wr[p] = 0; p_addr[p] = 0; p_dat[p] = 0; p_be[p] = 0;
        end
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b1;

        // Both ports hold reads continuously: grants must alternate starting at port 0.
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < NP; p++) if (!p_on[p]) put(p, 0, 1 + p, 32'd0, 4'h0);
            step();
        end
        drain();
        idle(3);

        put(0, 1, 5, 32'hDEADBEEF, 4'hF); drain();
        put(0, 0, 5, 32'd0, 4'h0);        drain();
        idle(3);

        put(1, 1, 9, 32'h11223344, 4'hF); drain();
        put(1, 1, 9, 32'hAABBCCDD, 4'h5); drain();
        put(1, 1, 9, 32'h99999999, 4'h0); drain();
        put(0, 0, 9, 32'd0, 4'h0);        drain();
        idle(3);

        put(1, 1, 199, 32'h0BADF00D, 4'hF); drain();
        put(1, 1, 210, 32'hFFFFFFFF, 4'hF); drain();
        put(1, 0, 210, 32'd0, 4'h0);        drain();
        put(0, 0, 199, 32'd0, 4'h0);        drain();
        idle(3);

        for (int i = 0; i < 4; i++) begin
            put(0, 1, i, 32'((i + 1) * 10), 4'hF);
            drain();
        end
        for (int i = 0; i < 4; i++) begin
            put(0, 0, i, 32'd0, 4'h0);
            step();
        end
        idle(3);

        // Read accepted, then reset in the following cycle: the response must never appear.
        put(0, 0, 5, 32'd0, 4'h0);
        step();
        do_reset(2);
        idle(3);
        put(1, 0, 5, 32'd0, 4'h0); drain();
        put(0, 0, 9, 32'd0, 4'h0); drain();
        idle(3);

        for (int k = 0; k < 1500; k++) begin
            for (int p = 0; p < NP; p++) begin
                if (!p_on[p] && $urandom_range(0, 3) != 0) begin
                    int a;
                    if ($urandom_range(0, 9) < 7) a = int'($urandom_range(0, 15));
                    else a = int'($urandom_range(180, 255));
                    put(p, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            step();
        end
        drain();
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
